// File: rtl/led_change_logger_pkg.sv
// Shared constants and record layout for the LED change logger.
// Build option: LED_CHANGE_LOGGER_TIMESTAMP_EN adds per-event timestamps.
package led_change_logger_pkg;

  // Default bus, FIFO and timestamp sizes.
  localparam int WIDTH_DEF    = 6;
  localparam int DEPTH_DEF    = 8;
  localparam int TS_WIDTH_DEF = 16;

  // One logged event at default widths: the new bus value and the
  // free-running counter value at the edge it was stored.
  typedef struct packed {
    logic [WIDTH_DEF-1:0]    value;
    logic [TS_WIDTH_DEF-1:0] ts;
  } evt_rec_t;

endpackage

// File: rtl/led_change_logger_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count.
// Clear has priority over push and pop. A push while full is accepted only
// when a pop happens on the same edge; otherwise it is dropped and the
// caller is expected to record the loss. Storage is not reset.
module event_fifo #(
  parameter int DW    = 22,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic          do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Pop only real entries; push when room exists or the head leaves this edge.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/led_change_logger.sv
// Logs every change of an asynchronous bus into an event FIFO.
// The bus is synchronised through two flops; a change is the synchronised
// value differing from the last logged value. Each change is pushed with
// the free-running timestamp sampled at the push edge.
// Build option: LED_CHANGE_LOGGER_TIMESTAMP_EN enables the timestamp counter
// and per-entry timestamp storage; without it evt_time is tied to zero.
//
// Event handshake: evt_valid is high whenever the FIFO holds at least one
// event and evt_value/evt_time show the oldest one. An event is consumed on
// a rising edge where evt_valid and evt_ready are both high; while evt_valid
// is high and evt_ready low the outputs hold. evt_ready while empty is ignored.
module led_change_logger
  import led_change_logger_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       sig_in,
  input  logic                   clear,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [WIDTH-1:0]       evt_value,
  output logic [TS_WIDTH-1:0]    evt_time,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow
);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] prev_q;
  logic             change;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  assign change = (sync_q2 != prev_q);

  // Two-flop synchroniser and last-logged value; clear does not touch these.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      sync_q1 <= sig_in;
      sync_q2 <= sync_q1;
      if (change) prev_q <= sync_q2;
    end
  end

`ifdef LED_CHANGE_LOGGER_TIMESTAMP_EN
  localparam int DW = WIDTH + TS_WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0]    value;
    logic [TS_WIDTH-1:0] ts;
  } rec_t;

  logic [TS_WIDTH-1:0] ts_q;
  rec_t                wr_rec;
  rec_t                rd_rec;
  logic [DW-1:0]       fifo_wdata;
  logic [DW-1:0]       fifo_rdata;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign wr_rec     = '{value: sync_q2, ts: ts_q};
  assign fifo_wdata = wr_rec;
  assign rd_rec     = fifo_rdata;
  assign evt_value  = rd_rec.value;
  assign evt_time   = rd_rec.ts;
`else
  localparam int DW = WIDTH;

  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_rdata;

  assign fifo_wdata = sync_q2;
  assign evt_value  = fifo_rdata;
  assign evt_time   = '0;
`endif

  event_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .pop   (evt_ready),
    .clear (clear),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (evt_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;

  // A change is lost only when full, nothing leaves and no flush is pending.
  assign drop = change & fifo_full & ~(evt_ready & ~fifo_empty) & ~clear;

  // Sticky loss flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_change_logger.sv
// Directed bench for led_change_logger: a default instance plus a 4-bit
// timestamp instance share the same stimulus and are checked every cycle
// against a queue model of the logged events.
module tb_led_change_logger;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       evt_ready;
  logic [5:0] sig_in;

  logic        evt_valid;
  logic [5:0]  evt_value;
  logic [15:0] evt_time;
  logic [3:0]  evt_count;
  logic        overflow;

  logic        v4;
  logic [5:0]  val4;
  logic [3:0]  time4;
  logic [3:0]  cnt4;
  logic        ovf4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_change_logger dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_value (evt_value),
    .evt_time  (evt_time),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  led_change_logger #(.TS_WIDTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .clear     (clear),
    .evt_valid (v4),
    .evt_ready (evt_ready),
    .evt_value (val4),
    .evt_time  (time4),
    .evt_count (cnt4),
    .overflow  (ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Events are kept as a plain queue; the bus value seen by the logger at an
  // edge is the one sampled two edges earlier; timestamps are edges since
  // reset release minus one.
  typedef struct {
    logic [5:0]  value;
    int unsigned ts;
  } mrec_t;

  mrec_t       mq[$];
  logic [5:0]  hist[$];
  logic [5:0]  last;
  bit          movf;
  int unsigned edges;
  logic [5:0]  m_seen;
  bit          m_chg;
  bit          m_pop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      hist.delete();
      hist.push_back(6'd0);
      hist.push_back(6'd0);
      last  = 6'd0;
      movf  = 0;
      edges = 0;
    end else begin
      m_seen = hist[0];
      hist.pop_front();
      hist.push_back(sig_in);
      m_chg = (m_seen != last);
      m_pop = evt_ready && (mq.size() != 0);
      if (clear) begin
        mq.delete();
        movf = 0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_chg) begin
          if (mq.size() < 8) mq.push_back('{value: m_seen, ts: edges});
          else movf = 1;
        end
      end
      if (m_chg) last = m_seen;
      edges++;
    end
  end

  // ---------------- per-cycle compare ----------------
  int          n_exp;
  logic [15:0] e16;
  logic [3:0]  e4;

  always @(negedge clk) begin
    n_exp = mq.size();
    check("evt_valid", evt_valid, n_exp != 0);
    check("evt_count", evt_count, n_exp);
    check("overflow", overflow, movf);
    check("evt_valid_ts4", v4, n_exp != 0);
    check("evt_count_ts4", cnt4, n_exp);
    check("overflow_ts4", ovf4, movf);
    if (n_exp != 0) begin
`ifdef LED_CHANGE_LOGGER_TIMESTAMP_EN
      e16 = 16'(mq[0].ts);
      e4  = 4'(mq[0].ts);
`else
      e16 = 16'd0;
      e4  = 4'd0;
`endif
      check("evt_value", evt_value, mq[0].value);
      check("evt_time", evt_time, e16);
      check("evt_value_ts4", val4, mq[0].value);
      check("evt_time_ts4", time4, e4);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] ts_exp(input int unsigned t);
`ifdef LED_CHANGE_LOGGER_TIMESTAMP_EN
    return t;
`else
    return 32'd0 & t;
`endif
  endfunction

  initial begin
    reset     = 1'b1;
    sig_in    = 6'b000101;
    clear     = 1'b0;
    evt_ready = 1'b0;
    #1 reset = 1'b0;
    step(2);
    check("reset_count", evt_count, 0);
    check("reset_valid", evt_valid, 0);
    check("reset_ovf", overflow, 0);

    // Nonzero bus at release logs exactly one event at timestamp 2.
    reset = 1'b1;
    step(2);
    check("release_count_early", evt_count, 0);
    step(1);
    check("release_count", evt_count, 1);
    check("release_value", evt_value, 6'b000101);
    check("release_time", evt_time, ts_exp(2));
    check("release_time4", time4, ts_exp(2));

    // Pop it, log a zero, flush, then ready while empty.
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("pop_to_empty", evt_count, 0);
    sig_in = 6'd0;
    step(4);
    check("zero_logged", evt_count, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_count", evt_count, 0);
    evt_ready = 1'b1;
    step(2);
    evt_ready = 1'b0;
    check("ready_empty", evt_count, 0);

    // Back-to-back changes 0 -> 1 -> 3.
    sig_in = 6'd1;
    step(1);
    sig_in = 6'd3;
    step(4);
    check("b2b_count", evt_count, 2);
    check("b2b_head", evt_value, 6'd1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("b2b_second", evt_value, 6'd3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // Nine changes into eight entries.
    for (int i = 0; i < 9; i++) begin
      sig_in = 6'(10 + i);
      step(1);
    end
    step(3);
    check("ovf_count", evt_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", evt_value, 6'd10);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("ovf_clear_count", evt_count, 0);
    check("ovf_clear_flag", overflow, 0);

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 8; i++) begin
      sig_in = 6'(20 + i);
      step(1);
    end
    step(3);
    check("full_count", evt_count, 8);
    sig_in = 6'd40;
    step(2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("pushpop_count", evt_count, 8);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_head", evt_value, 6'd21);
    evt_ready = 1'b1;
    step(7);
    evt_ready = 1'b0;
    check("pushpop_tail", evt_value, 6'd40);
    check("pushpop_left", evt_count, 1);

    // Change landing on a clear cycle is discarded and not relogged.
    sig_in = 6'd41;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(3);
    check("clear_discard", evt_count, 0);

    // Reset mid-operation, then timestamps 20 edges apart (3 and 23).
    sig_in = 6'd42;
    step(4);
    check("pre_reset_count", evt_count, 1);
    reset = 1'b0;
    step(1);
    check("mid_reset_count", evt_count, 0);
    sig_in = 6'd0;
    reset  = 1'b1;
    step(1);
    sig_in = 6'd1;
    step(3);
    check("wrap_first_count", evt_count, 1);
    check("wrap_first_time", evt_time, ts_exp(3));
    check("wrap_first_time4", time4, ts_exp(3));
    step(17);
    sig_in = 6'd2;
    step(3);
    check("wrap_second_count", evt_count, 2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("wrap_second_time", evt_time, ts_exp(23));
    check("wrap_second_time4", time4, ts_exp(7));

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_change_logger.md
LED_CHANGE_LOGGER -- requirements
Module: led_change_logger

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the width of the monitored input bus.
REQ-002 Parameter DEPTH, default 8, power of two >= 2, SHALL set event FIFO entries.
REQ-003 Parameter TS_WIDTH, default 16, SHALL set timestamp width.
REQ-004 CLK  input  1  SHALL be the single clock; all state on rising edge.
REQ-005 RESET  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 SIG_IN  input  WIDTH  SHALL be the monitored bus (asynchronous to CLK).
REQ-007 CLEAR  input  1  SHALL be a synchronous flush request.
REQ-008 EVT_VALID  output  1  SHALL flag that an event is at the FIFO head.
REQ-009 EVT_READY  input  1  SHALL pop the head when high with EVT_VALID.
REQ-010 EVT_VALUE  output  WIDTH  SHALL be the head event's new bus value.
REQ-011 EVT_TIME  output  TS_WIDTH  SHALL be the head event's timestamp.
REQ-012 EVT_COUNT  output  $clog2(DEPTH)+1  SHALL be the number of stored events.
REQ-013 OVERFLOW  output  1  SHALL be the sticky flag for a dropped event.

Function
REQ-014 SIG_IN SHALL pass a 2-flop synchronizer; a previous-value register holds the last logged value.
REQ-015 A change SHALL be detected when synchronized value != previous value; previous value updates to it on that edge.
REQ-016 Change on SIG_IN before edge n SHALL push at edge n+2; EVT_VALID high after edge n+2 when FIFO was empty.
REQ-017 Each push SHALL store {synchronized value, free-running counter value at the push edge}.
REQ-018 Timestamp counter SHALL increment every cycle, wrapping 2^TS_WIDTH-1 -> 0 without flag.
REQ-019 FIFO SHALL be first-word-fall-through; EVT_VALID = (EVT_COUNT != 0); outputs stable while EVT_VALID & !EVT_READY.
REQ-020 EVT_READY with FIFO empty SHALL have no effect.
REQ-021 Push while full and no pop SHALL drop the event, leave FIFO unchanged, set OVERFLOW.
REQ-022 Push and pop same edge SHALL both occur, count unchanged, including when full (no overflow).
REQ-023 CLEAR SHALL empty the FIFO and clear OVERFLOW next edge; it has priority over push and pop in that cycle (change discarded, previous-value still updates).
REQ-024 CLEAR SHALL NOT reset the timestamp counter, synchronizer or previous-value register.
REQ-025 Back-to-back changes on consecutive cycles SHALL each log one event.

Reset
REQ-026 RESET low SHALL asynchronously zero synchronizer, previous value, counter, FIFO pointers, EVT_COUNT, OVERFLOW; EVT_VALID=0.
REQ-027 Previous value resets to 0, so nonzero SIG_IN at reset release SHALL log one event.
REQ-028 Reset mid-operation SHALL discard all stored events; FIFO memory needs no reset.

Configuration
REQ-029 With LED_CHANGE_LOGGER_TIMESTAMP_EN defined, counter and per-entry timestamp storage SHALL exist as above.
REQ-030 Without LED_CHANGE_LOGGER_TIMESTAMP_EN, counter and timestamp storage SHALL be absent and EVT_TIME tied to 0; other behaviour identical.

Structure
REQ-031 Shared package SHALL hold default WIDTH/DEPTH/TS_WIDTH constants and the event-record typedef {value, time}.
REQ-032 FIFO SHALL be sub-module event_fifo (parametrised width/depth, push/pop/clear, count, full/empty).

Verification
REQ-033 Reset, SIG_IN=6'b000101 at release -> one event VALUE=000101, TIME=2; EVT_COUNT=1.
REQ-034 SIG_IN 0->1->3 on consecutive cycles, EVT_READY=0 -> two events, VALUE 000001 then 000011, TIME differs by 1.
REQ-035 DEPTH=8, 9 changes without pop -> EVT_COUNT=8, OVERFLOW=1, head = first change; CLEAR -> COUNT=0, OVERFLOW=0.
REQ-036 FIFO full, change plus EVT_READY same cycle -> COUNT stays 8, OVERFLOW stays 0, new tail = new value.
REQ-037 TS_WIDTH=4, changes 20 cycles apart -> EVT_TIME wraps mod 16 (e.g. 3 then 7).
REQ-038 Build without LED_CHANGE_LOGGER_TIMESTAMP_EN -> EVT_TIME always 0, REQ-033..036 values otherwise unchanged.
